// File: rtl/debug_ram_master.sv
// Debug RAM initiator: turns single writes and read bursts into one-cycle RAM accesses.
// Latency: write response two cycles after accept, read beat three; bad start address responds next cycle.
// Backpressure: rsp_rdy low holds the response stable and issues no further RAM cycles; req_rdy only in IDLE.
module debug_ram_master #(
    parameter int SRAM_DEPTH     = 16,
    parameter int SRAM_DEPTH_LOG = $clog2(SRAM_DEPTH),
    parameter int ADDR_W         = 8,
    parameter int LEN_W          = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_vld,
    output logic                      req_rdy,
    input  logic                      req_wr,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [LEN_W-1:0]          req_len,
    input  logic [31:0]               req_wdat,
    output logic                      rsp_vld,
    input  logic                      rsp_rdy,
    output logic [31:0]               rsp_rdat,
    output logic                      rsp_last,
    output logic                      rsp_err,
    output logic                      ram_cs,
    output logic                      ram_wr_en,
    output logic [SRAM_DEPTH_LOG-1:0] ram_addr,
    output logic [31:0]               ram_wdat,
    input  logic [31:0]               ram_dout
);

    typedef enum logic [1:0] {IDLE, ACC, RDW, RESP} state_t;

    localparam logic [ADDR_W:0]           DEPTH_L = (ADDR_W+1)'(SRAM_DEPTH);
    localparam logic [SRAM_DEPTH_LOG-1:0] TOP_A   = SRAM_DEPTH_LOG'(SRAM_DEPTH - 1);

    state_t                    state_q, state_d;
    logic                      req_rdy_q, req_rdy_d;
    logic                      wr_q, wr_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [LEN_W-1:0]          beat_cnt_q, beat_cnt_d;
    logic                      rsp_vld_q, rsp_vld_d;
    logic [31:0]               rsp_rdat_q, rsp_rdat_d;
    logic                      rsp_last_q, rsp_last_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      ram_cs_q, ram_cs_d;
    logic                      ram_wr_en_q, ram_wr_en_d;
    logic [SRAM_DEPTH_LOG-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]               ram_wdat_q, ram_wdat_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_rdy_q   <= 1'b1;
            wr_q        <= 1'b0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_rdat_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            ram_cs_q    <= 1'b0;
            ram_wr_en_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdat_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_rdy_q   <= req_rdy_d;
            wr_q        <= wr_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdat_q  <= rsp_rdat_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
            ram_cs_q    <= ram_cs_d;
            ram_wr_en_q <= ram_wr_en_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdat_q  <= ram_wdat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        len_d       = len_q;
        beat_cnt_d  = beat_cnt_q;
        rsp_vld_d   = rsp_vld_q;
        rsp_rdat_d  = rsp_rdat_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;
        ram_cs_d    = ram_cs_q;
        ram_wr_en_d = ram_wr_en_q;
        ram_addr_d  = ram_addr_q;
        ram_wdat_d  = ram_wdat_q;

        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    wr_d       = req_wr;
                    len_d      = req_len;
                    ram_wdat_d = req_wdat;
                    if ({1'b0, req_addr} >= DEPTH_L) begin
                        state_d    = RESP;
                        rsp_vld_d  = 1'b1;
                        rsp_err_d  = 1'b1;
                        rsp_last_d = 1'b1;
                        rsp_rdat_d = '0;
                    end else begin
                        // Strobe is registered here so it is high for the whole ACC cycle.
                        ram_addr_d  = req_addr[SRAM_DEPTH_LOG-1:0];
                        beat_cnt_d  = '0;
                        ram_cs_d    = 1'b1;
                        ram_wr_en_d = req_wr;
                        state_d     = ACC;
                    end
                end
            end
            ACC: begin
                ram_cs_d    = 1'b0;
                ram_wr_en_d = 1'b0;
                if (wr_q) begin
                    state_d    = RESP;
                    rsp_vld_d  = 1'b1;
                    rsp_rdat_d = '0;
                    rsp_last_d = 1'b1;
                    rsp_err_d  = 1'b0;
                end else begin
                    state_d = RDW;
                end
            end
            RDW: begin
                state_d    = RESP;
                rsp_vld_d  = 1'b1;
                rsp_rdat_d = ram_dout;
                rsp_last_d = (beat_cnt_q == len_q);
                rsp_err_d  = 1'b0;
            end
            RESP: begin
                if (rsp_rdy) begin
                    rsp_vld_d = 1'b0;
                    if (!rsp_last_q) begin
                        beat_cnt_d  = beat_cnt_q + 1'b1;
                        ram_addr_d  = (ram_addr_q == TOP_A) ? '0 : ram_addr_q + 1'b1;
                        ram_cs_d    = 1'b1;
                        ram_wr_en_d = wr_q;
                        state_d     = ACC;
                    end else begin
                        rsp_last_d = 1'b0;
                        rsp_err_d  = 1'b0;
                        rsp_rdat_d = '0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        req_rdy_d = (state_d == IDLE);
    end

    assign req_rdy   = req_rdy_q;
    assign rsp_vld   = rsp_vld_q;
    assign rsp_rdat  = rsp_rdat_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_err   = rsp_err_q;
    assign ram_cs    = ram_cs_q;
    assign ram_wr_en = ram_wr_en_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdat  = ram_wdat_q;

endmodule

// File: tb/tb_debug_ram_master.sv
// Bench for debug_ram_master: directed requests, expected RAM cycles and responses queued,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_debug_ram_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_vld, req_rdy, req_wr;
    logic [7:0]  req_addr;
    logic [3:0]  req_len;
    logic [31:0] req_wdat;
    logic        rsp_vld, rsp_rdy, rsp_last, rsp_err;
    logic [31:0] rsp_rdat;
    logic        ram_cs, ram_wr_en;
    logic [3:0]  ram_addr;
    logic [31:0] ram_wdat, ram_dout;

    always #5 clk = ~clk;

    debug_ram_master #(
        .SRAM_DEPTH(16), .SRAM_DEPTH_LOG(4), .ADDR_W(8), .LEN_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
        .req_addr(req_addr), .req_len(req_len), .req_wdat(req_wdat),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdat(rsp_rdat),
        .rsp_last(rsp_last), .rsp_err(rsp_err),
        .ram_cs(ram_cs), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
        .ram_wdat(ram_wdat), .ram_dout(ram_dout)
    );

    // Registered-read RAM model
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_wr_en) mem[ram_addr] <= ram_wdat;
            else           ram_dout <= mem[ram_addr];
        end
    end

    typedef struct {
        logic [31:0] rdat;
        logic        last;
        logic        err;
        int          vmin;
        int          vmax;
    } rsp_t;

    typedef struct {
        logic [3:0]  addr;
        logic        wr;
        logic [31:0] wdat;
        int          c;
    } cs_t;

    rsp_t        rsp_q[$];
    cs_t         cs_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          stall_n = 0;
    int          scnt = 0;
    logic [31:0] shadow [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response-ready driver: holds rsp_rdy low for stall_n cycles of each valid beat
    initial begin
        rsp_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rsp_vld) begin
                if (scnt < stall_n) begin
                    rsp_rdy = 1'b0;
                    scnt++;
                end else begin
                    rsp_rdy = 1'b1;
                end
            end else begin
                scnt    = 0;
                rsp_rdy = (stall_n == 0);
            end
        end
    end

    // Monitor
    logic        prev_vld = 1'b0;
    logic        prev_hs = 1'b0;
    logic [31:0] prev_rdat;
    logic        prev_last;
    int          rise_cyc = 0;
    cs_t         ce;
    rsp_t        re;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ram_cs) begin
                    if (cs_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_ram_cs: got addr=%0d wr=%0b required no access", ram_addr, ram_wr_en);
                    end else begin
                        ce = cs_q.pop_front();
                        chk("cs_addr", 32'(ram_addr), 32'(ce.addr));
                        chk("cs_wr_en", 32'(ram_wr_en), 32'(ce.wr));
                        if (ce.wr) chk("cs_wdat", ram_wdat, ce.wdat);
                        if (ce.c >= 0) chk("cs_cycle", 32'(cyc), 32'(ce.c));
                    end
                end
                if (rsp_vld && !prev_vld) rise_cyc = cyc;
                if (rsp_vld && prev_vld && !prev_hs) begin
                    chk("stall_rdat", rsp_rdat, prev_rdat);
                    chk("stall_last", 32'(rsp_last), 32'(prev_last));
                    chk("stall_req_rdy", 32'(req_rdy), 32'd0);
                end
                if (rsp_vld && rsp_rdy) begin
                    if (rsp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_rsp: got rdat=%h last=%0b err=%0b required none", rsp_rdat, rsp_last, rsp_err);
                    end else begin
                        re = rsp_q.pop_front();
                        chk("rsp_rdat", rsp_rdat, re.rdat);
                        chk("rsp_last", 32'(rsp_last), 32'(re.last));
                        chk("rsp_err", 32'(rsp_err), 32'(re.err));
                        if (re.vmin >= 0) begin
                            n_cmp++;
                            if (rise_cyc < re.vmin || rise_cyc > re.vmax) begin
                                n_bad++;
                                $display("FAIL rsp_latency: got cycle %0d required %0d..%0d", rise_cyc, re.vmin, re.vmax);
                            end
                        end
                    end
                end
                prev_vld  = rsp_vld;
                prev_hs   = rsp_vld && rsp_rdy;
                prev_rdat = rsp_rdat;
                prev_last = rsp_last;
            end else begin
                prev_vld = 1'b0;
                prev_hs  = 1'b0;
            end
        end
    end

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [3:0] len,
                         input logic [31:0] wdat, output int k);
        int w = 0;
        @(posedge clk); #1;
        while (!req_rdy && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (!req_rdy) begin
            n_cmp++; n_bad++;
            $display("FAIL req_rdy_timeout: got req_rdy=0 required 1 within 200 cycles");
        end
        req_vld  = 1'b1;
        req_wr   = wr;
        req_addr = addr;
        req_len  = len;
        req_wdat = wdat;
        k        = cyc;
        @(posedge clk); #1;
        req_vld  = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        int k;
        issue(1'b1, a, 4'd0, d, k);
        shadow[a[3:0]] = d;
        cs_q.push_back('{addr: a[3:0], wr: 1'b1, wdat: d, c: k + 1});
        rsp_q.push_back('{rdat: 32'd0, last: 1'b1, err: 1'b0, vmin: k + 2, vmax: k + 2});
    endtask

    task automatic do_read(input logic [7:0] a, input logic [3:0] len);
        int k;
        logic [3:0] ad;
        issue(1'b0, a, len, 32'h0, k);
        for (int i = 0; i <= int'(len); i++) begin
            ad = 4'(a + 8'(i));
            cs_q.push_back('{addr: ad, wr: 1'b0, wdat: 32'd0, c: (i == 0) ? k + 1 : -1});
            rsp_q.push_back('{rdat: shadow[ad], last: (i == int'(len)), err: 1'b0,
                              vmin: (i == 0) ? k + 3 : -1, vmax: (i == 0) ? k + 3 : -1});
        end
    endtask

    task automatic do_err(input logic [7:0] a);
        int k;
        issue(1'b0, a, 4'd2, 32'h0, k);
        rsp_q.push_back('{rdat: 32'd0, last: 1'b1, err: 1'b1, vmin: k + 1, vmax: k + 2});
    endtask

    task automatic drain();
        int w = 0;
        while ((rsp_q.size() != 0 || cs_q.size() != 0) && w < 500) begin
            @(posedge clk);
            w++;
        end
        repeat (3) @(posedge clk);
        chk("drain_rsp_pending", 32'(rsp_q.size()), 32'd0);
        chk("drain_cs_pending", 32'(cs_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_rdy"}, 32'(req_rdy), 32'd1);
        chk({tag, "_rsp_vld"}, 32'(rsp_vld), 32'd0);
        chk({tag, "_rsp_last"}, 32'(rsp_last), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_rsp_rdat"}, rsp_rdat, 32'd0);
        chk({tag, "_ram_cs"}, 32'(ram_cs), 32'd0);
        chk({tag, "_ram_wr_en"}, 32'(ram_wr_en), 32'd0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_ram_wdat"}, ram_wdat, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n    = 1'b0;
        req_vld  = 1'b0;
        req_wr   = 1'b0;
        req_addr = '0;
        req_len  = '0;
        req_wdat = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single write then single read back
        do_write(8'd3, 32'hDEADBEEF);
        drain();
        do_read(8'd3, 4'd0);
        drain();

        // Burst wrapping from the top of the RAM
        do_write(8'd14, 32'hA0A0_0014);
        do_write(8'd15, 32'hB0B0_0015);
        do_write(8'd0,  32'hC0C0_0000);
        do_write(8'd1,  32'hD0D0_0001);
        drain();
        do_read(8'd14, 4'd3);
        drain();

        // Out-of-range start addresses
        do_err(8'd16);
        drain();
        do_err(8'd255);
        drain();

        // Backpressured burst
        stall_n = 5;
        do_read(8'd15, 4'd2);
        drain();

        // Reset while a burst response is stalled
        stall_n = 4;
        do_read(8'd14, 4'd3);
        w = 0;
        while (!rsp_vld && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("pre_reset_rsp_vld", 32'(rsp_vld), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        rsp_q.delete();
        cs_q.delete();
        #2;
        check_reset_outputs("midburst_reset");
        @(posedge clk); #1;
        rst_n   = 1'b1;
        stall_n = 0;
        do_read(8'd3, 4'd0);
        drain();
        do_write(8'd7, 32'h1234_5678);
        do_read(8'd7, 4'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
